// File: rtl/serial_adder_driver.sv
// Parallel-to-serial operand driver and serial-to-parallel result collector
// for a bit-serial adder: operands go out LSB-first, returned sum bits are reassembled.
module serial_adder_driver #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LW-1:0]    in_len,
  input  logic             pause,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last,
  input  logic             sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; the sender holds valid and data stable until then.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    eff_len;

  // A zero or oversized length request means a full-width operation.
  always_comb begin
    eff_len = in_len;
    if ((in_len == '0) || (in_len > LW'(WIDTH))) eff_len = LW'(WIDTH);
  end

  // Beat outputs follow pause in the same cycle, so they are decoded from
  // registered state rather than registered themselves; reset drops them at once.
  assign in_ready  = (state == IDLE);
  assign res_valid = (state == RESULT);
  assign vld       = (state == SHIFT) && !pause;
  assign a         = vld && shift_a[0];
  assign b         = vld && shift_b[0];
  assign last      = vld && (cnt == LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      cnt     <= '0;
      idx     <= '0;
      res_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_a <= in_a;
            shift_b <= in_b;
            cnt     <= eff_len;
            idx     <= '0;
            res_sum <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!pause) begin
            res_sum <= res_sum | ({{(WIDTH-1){1'b0}}, sum} << idx);
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            idx     <= idx + LW'(1);
            cnt     <= cnt - LW'(1);
            if (cnt == LW'(1)) state <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder_driver.md
Name: serial_adder_driver

Overview:
- Transmitter/collector for the bit-serial adder protocol (vld, a, b, last in; sum out).
- Accepts two parallel operands and a bit length over a valid/ready handshake, then emits them LSB-first as a bit-serial stream with vld/last.
- Samples the returned serial sum bit on every valid beat and reassembles it into a parallel result, presented over a valid/ready handshake.
- Sits between parallel datapath logic and a serial adder instance.

Parameters:
- WIDTH, 8, maximum operand/result width in bits (>=2).
- LW, $clog2(WIDTH+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  driver can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_len  input  LW  number of bits to send. Legal 1..WIDTH; 0 or >WIDTH means WIDTH.
- pause  input  1  stall; suppresses the serial beat in the current cycle.
- vld  output  1  serial beat valid.
- a  output  1  current bit of A.
- b  output  1  current bit of B.
- last  output  1  final bit of the operation; only ever high together with vld.
- sum  input  1  serial sum bit from the adder, same cycle as a/b (combinational path in adder).
- res_valid  output  1  parallel result available.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  reassembled sum. Bits at index >= len are 0; final carry is discarded.

Behaviour:
- Reset (async, immediate), all outputs 0 except in_ready: state=IDLE, in_ready=1, vld=0, a=0, b=0, last=0, res_valid=0, res_sum=0, shift registers/counters 0.
- FSM states: IDLE, SHIFT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load shift_a=in_a, shift_b=in_b, cnt=effective len, idx=0, res_sum=0; go to SHIFT.
  - in_a/in_b/in_len are sampled only on this handshake edge.
- SHIFT:
  - in_ready=0; vld=!pause; a=shift_a[0]&vld; b=shift_b[0]&vld; last=vld&(cnt==1).
  - On a beat (vld=1):
    - res_sum[idx] <= sum.
    - shift_a/shift_b shift right by 1.
    - idx++, cnt--.
  - If last, go to RESULT.
  - pause=1: no shift, no capture, counters hold; a/b/last=0.
- RESULT: res_valid=1, res_sum stable, in_ready=0. On res_ready go to IDLE (res_valid drops next cycle).
- Latency, no pause:
  - Request handshake at edge E0; first beat in cycle after E0.
  - Last beat in the len-th cycle after E0; res_valid high in the following cycle.
  - Total E0 to res_valid = len+1 cycles.
- Throughput: a new request is accepted no earlier than the cycle after the result handshake (IDLE lasts >=1 cycle).
- No beat is emitted outside SHIFT; vld never high in IDLE/RESULT.
- len=1: single beat with vld=1 and last=1 together.
- Reset mid-SHIFT or mid-RESULT: operation aborted, result lost, no further beats; vld/last drop asynchronously. The downstream adder is reset by the same rst.
- in_valid while not ready: ignored (held by sender per valid/ready rules).
- sum is ignored whenever vld=0.

Test Plan (WIDTH=8, driver looped back through a serial adder with vld):
- len=8, in_a=0x5A, in_b=0x3C, pause=0 -> 8 consecutive vld beats, last only on the 8th, res_valid in the next cycle, res_sum=0x96.
- len=8, in_a=0xFF, in_b=0x01 -> res_sum=0x00 (carry dropped); a following op 0x01+0x01 gives 0x02, proving the adder carry was cleared by last.
- len=4, in_a=0xF7, in_b=0x01 -> exactly 4 beats, res_sum=0x08 (upper bits 0). len=0 with 0x12+0x34 -> 8 beats, res_sum=0x46.
- len=8, 0x5A+0x3C, pause high during beats 3-5 -> vld=0 for those 3 cycles, 11 cycles from handshake to last, res_sum=0x96.
- res_ready low for 5 cycles after res_valid -> res_valid and res_sum held, in_ready=0. Then res_ready=1 -> next request accepted the cycle after IDLE is reached; back-to-back ops both correct.
- rst pulsed during the 4th beat -> vld/last/res_valid go 0 immediately, in_ready=1 after release. A fresh op 0x10+0x20 (len=8) yields 0x30.
